// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl : load/store unit sequencer
//
// Accepts one decoded load/store uOP from issue, forms the effective address
// (base + immediate), checks alignment, runs a single-outstanding
// request/ack transaction on the data-memory port and returns the
// sign/zero-extended load result (or store completion) with a one-cycle
// done pulse.
//
// Handshakes:
//   issue side  : a uOP is accepted on a rising edge where valid_in=1 and
//                 ready_out=1. ready_out is high only in IDLE.
//   memory side : mem_req_out stays high, with address/strobes/data held
//                 stable, until a rising edge where mem_ack_in=1 (or the
//                 timeout fires). mem_rdata_in is sampled on that same edge.
//                 mem_ack_in is ignored whenever mem_req_out is low.
//
// Ports:
//   clock_in        system clock, all state on the rising edge
//   reset_in        asynchronous active-low reset
//   valid_in        issue presents a uOP
//   ready_out       controller can accept a uOP (IDLE)
//   uop_in[3:0]     LB/LH/LW/LBU/LHU/SB/SH/SW, other codes are NOP
//   a_data_in[31:0] base register value
//   b_data_in[31:0] immediate offset
//   st_data_in[31:0] store source value
//   mem_req_out     memory request valid
//   mem_we_out      1 = store
//   mem_addr_out    word-aligned address
//   mem_wstrb_out   byte enables
//   mem_wdata_out   store data replicated into lanes
//   mem_ack_in      memory completes the request this cycle
//   mem_rdata_in    read word, valid with mem_ack_in
//   done_out        one-cycle completion pulse
//   res_data_out    load result (0 for stores, NOP and exceptions)
//   misalign_out    with done_out: misaligned, no memory op issued
//   bus_err_out     with done_out: request timed out
//   dbg_state_out   current FSM state (0 IDLE, 1 REQ, 2 RESP)
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [3:0]  uop_in,
    input  logic [31:0] a_data_in,
    input  logic [31:0] b_data_in,
    input  logic [31:0] st_data_in,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [3:0]  mem_wstrb_out,
    output logic [31:0] mem_wdata_out,
    input  logic        mem_ack_in,
    input  logic [31:0] mem_rdata_in,
    output logic        done_out,
    output logic [31:0] res_data_out,
    output logic        misalign_out,
    output logic        bus_err_out,
    output logic [1:0]  dbg_state_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0101;
    localparam logic [3:0] OP_LHU = 4'b0110;
    localparam logic [3:0] OP_SB  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1100;

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT);

    function automatic logic is_load(input logic [3:0] u);
        return (u == OP_LB) || (u == OP_LH) || (u == OP_LW) ||
               (u == OP_LBU) || (u == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] u);
        return (u == OP_SB) || (u == OP_SH) || (u == OP_SW);
    endfunction

    function automatic logic is_half(input logic [3:0] u);
        return (u == OP_LH) || (u == OP_LHU) || (u == OP_SH);
    endfunction

    function automatic logic is_word(input logic [3:0] u);
        return (u == OP_LW) || (u == OP_SW);
    endfunction

    state_t      state, state_next;
    logic [3:0]  uop_q;
    logic [31:0] ea_q;
    logic [31:0] st_q;
    logic [31:0] rdata_q;
    logic [31:0] cnt_q;
    logic        misalign_q;
    logic        bus_err_q;

    logic [31:0] ea;
    logic        misalign_now;
    logic        nop_now;
    logic        timeout_hit;
    logic [1:0]  sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;
    logic [3:0]  strb_calc;
    logic [31:0] wdata_calc;

    // Carry out of the 32-bit add is intentionally dropped.
    assign ea = a_data_in + b_data_in;

    assign nop_now      = !(is_load(uop_in) || is_store(uop_in));
    assign misalign_now = (is_half(uop_in) && ea[0]) ||
                          (is_word(uop_in) && (ea[1:0] != 2'b00));

    // The counter holds the number of REQ cycles already spent without an
    // ack, so the current cycle is number cnt_q+1. Timing out on that cycle
    // gives exactly TIMEOUT request cycles; an ack in the same cycle wins.
    assign timeout_hit = (TIMEOUT_LIM != 32'd0) &&
                         ((cnt_q + 32'd1) == TIMEOUT_LIM);

    assign sh = ea_q[1:0];

    always_comb begin
        ld_byte = 8'h00;
        unique case (sh)
            2'd0: ld_byte = rdata_q[7:0];
            2'd1: ld_byte = rdata_q[15:8];
            2'd2: ld_byte = rdata_q[23:16];
            2'd3: ld_byte = rdata_q[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = sh[1] ? rdata_q[31:16] : rdata_q[15:0];

        ld_result = 32'd0;
        unique case (uop_q)
            OP_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_result = {24'd0, ld_byte};
            OP_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_result = {16'd0, ld_half};
            OP_LW:   ld_result = rdata_q;
            default: ld_result = 32'd0;
        endcase
    end

    always_comb begin
        strb_calc  = 4'b0000;
        wdata_calc = 32'd0;
        unique case (uop_q)
            OP_SB: begin
                strb_calc  = 4'b0001 << sh;
                wdata_calc = {4{st_q[7:0]}};
            end
            OP_SH: begin
                strb_calc  = 4'b0011 << sh;
                wdata_calc = {2{st_q[15:0]}};
            end
            OP_SW: begin
                strb_calc  = 4'b1111;
                wdata_calc = st_q;
            end
            default: begin
                strb_calc  = 4'b0000;
                wdata_calc = 32'd0;
            end
        endcase
    end

    // State register and datapath latches.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state      <= IDLE;
            uop_q      <= 4'd0;
            ea_q       <= 32'd0;
            st_q       <= 32'd0;
            rdata_q    <= 32'd0;
            cnt_q      <= 32'd0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        uop_q      <= uop_in;
                        ea_q       <= ea;
                        st_q       <= st_data_in;
                        rdata_q    <= 32'd0;
                        cnt_q      <= 32'd0;
                        misalign_q <= misalign_now && !nop_now;
                        bus_err_q  <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_ack_in) begin
                        if (is_load(uop_q)) begin
                            rdata_q <= mem_rdata_in;
                        end
                    end else if (timeout_hit) begin
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                RESP: begin
                    cnt_q <= 32'd0;
                end
                default: begin
                    cnt_q <= 32'd0;
                end
            endcase
        end
    end

    // Next state and outputs. Everything is decoded from state and latched
    // values, so an asynchronous reset drops mem_req_out at once.
    always_comb begin
        state_next    = state;
        ready_out     = 1'b0;
        mem_req_out   = 1'b0;
        mem_we_out    = 1'b0;
        mem_addr_out  = 32'd0;
        mem_wstrb_out = 4'b0000;
        mem_wdata_out = 32'd0;
        done_out      = 1'b0;
        res_data_out  = 32'd0;
        misalign_out  = 1'b0;
        bus_err_out   = 1'b0;

        unique case (state)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) begin
                    if (nop_now || misalign_now) begin
                        state_next = RESP;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                mem_req_out   = 1'b1;
                mem_we_out    = is_store(uop_q);
                mem_addr_out  = {ea_q[31:2], 2'b00};
                mem_wstrb_out = strb_calc;
                mem_wdata_out = wdata_calc;
                if (mem_ack_in || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                done_out     = 1'b1;
                misalign_out = misalign_q;
                bus_err_out  = bus_err_q;
                if (is_load(uop_q) && !misalign_q && !bus_err_q) begin
                    res_data_out = ld_result;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dbg_state_out = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl : directed self-checking bench for lsu_ctrl (TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clock_in;
    logic        reset_in;
    logic        valid_in;
    logic        ready_out;
    logic [3:0]  uop_in;
    logic [31:0] a_data_in;
    logic [31:0] b_data_in;
    logic [31:0] st_data_in;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [3:0]  mem_wstrb_out;
    logic [31:0] mem_wdata_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;
    logic        done_out;
    logic [31:0] res_data_out;
    logic        misalign_out;
    logic        bus_err_out;
    logic [1:0]  dbg_state_out;

    int checks;
    int failures;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .uop_in        (uop_in),
        .a_data_in     (a_data_in),
        .b_data_in     (b_data_in),
        .st_data_in    (st_data_in),
        .mem_req_out   (mem_req_out),
        .mem_we_out    (mem_we_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wstrb_out (mem_wstrb_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_ack_in    (mem_ack_in),
        .mem_rdata_in  (mem_rdata_in),
        .done_out      (done_out),
        .res_data_out  (res_data_out),
        .misalign_out  (misalign_out),
        .bus_err_out   (bus_err_out),
        .dbg_state_out (dbg_state_out)
    );

    // Clock / reset
    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one uOP and follow it to its done pulse. ack_at is the REQ cycle
    // (1-based) in which mem_ack_in is raised, 0 for never; exp_lat is the
    // number of cycles from acceptance to done_out.
    task automatic run_op(input string tag, input logic [3:0] u,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] st, input logic [31:0] rd,
                          input int ack_at, input int exp_lat,
                          input logic [31:0] e_addr, input logic e_we,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input logic [31:0] e_res, input logic e_mis,
                          input logic e_berr);
        int cyc;
        @(negedge clock_in);
        chk({tag, "_ready"}, 32'(ready_out), 32'd1);
        valid_in   = 1'b1;
        uop_in     = u;
        a_data_in  = a;
        b_data_in  = b;
        st_data_in = st;
        @(negedge clock_in);
        // Scramble inputs so the DUT must rely on its latched copies.
        valid_in   = 1'b0;
        uop_in     = 4'($urandom_range(0, 15));
        a_data_in  = $urandom;
        b_data_in  = $urandom;
        st_data_in = $urandom;
        cyc = 1;
        while (!done_out && cyc <= 20) begin
            chk({tag, "_req"},   32'(mem_req_out),   32'd1);
            chk({tag, "_addr"},  mem_addr_out,       e_addr);
            chk({tag, "_we"},    32'(mem_we_out),    32'(e_we));
            chk({tag, "_wstrb"}, 32'(mem_wstrb_out), 32'(e_strb));
            chk({tag, "_wdata"}, mem_wdata_out,      e_wdata);
            chk({tag, "_nordy"}, 32'(ready_out),     32'd0);
            mem_ack_in   = (cyc == ack_at);
            mem_rdata_in = (cyc == ack_at) ? rd : $urandom;
            @(negedge clock_in);
            mem_ack_in   = 1'b0;
            mem_rdata_in = $urandom;
            cyc++;
        end
        chk({tag, "_lat"},    32'(cyc),          32'(exp_lat));
        chk({tag, "_done"},   32'(done_out),     32'd1);
        chk({tag, "_res"},    res_data_out,      e_res);
        chk({tag, "_mis"},    32'(misalign_out), 32'(e_mis));
        chk({tag, "_berr"},   32'(bus_err_out),  32'(e_berr));
        chk({tag, "_rsp_req"}, 32'(mem_req_out), 32'd0);
        chk({tag, "_rsp_rdy"}, 32'(ready_out),   32'd0);
        @(negedge clock_in);
        chk({tag, "_pulse"},  32'(done_out),     32'd0);
        chk({tag, "_idle"},   32'(ready_out),    32'd1);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset_in     = 1'b0;
        valid_in     = 1'b0;
        uop_in       = 4'd0;
        a_data_in    = 32'd0;
        b_data_in    = 32'd0;
        st_data_in   = 32'd0;
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'd0;

        // Reset state
        repeat (3) @(negedge clock_in);
        chk("rst_ready", 32'(ready_out),     32'd1);
        chk("rst_req",   32'(mem_req_out),   32'd0);
        chk("rst_we",    32'(mem_we_out),    32'd0);
        chk("rst_addr",  mem_addr_out,       32'd0);
        chk("rst_wstrb", 32'(mem_wstrb_out), 32'd0);
        chk("rst_wdata", mem_wdata_out,      32'd0);
        chk("rst_done",  32'(done_out),      32'd0);
        chk("rst_res",   res_data_out,       32'd0);
        chk("rst_mis",   32'(misalign_out),  32'd0);
        chk("rst_berr",  32'(bus_err_out),   32'd0);
        chk("rst_state", 32'(dbg_state_out), 32'd0);
        reset_in = 1'b1;
        @(negedge clock_in);

        // Ack while idle must be ignored
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h12345678;
        @(negedge clock_in);
        mem_ack_in = 1'b0;
        chk("idle_ack_done", 32'(done_out),    32'd0);
        chk("idle_ack_req",  32'(mem_req_out), 32'd0);

        //      tag    uop      a             b     st            rdata        ack lat addr          we  strb     wdata         res          mis berr
        run_op("lw",   4'b0011, 32'h1000,     32'h4, 32'h0,       32'hDEADBEEF, 1, 2, 32'h1004,     0, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 0);
        run_op("lb",   4'b0001, 32'h2000,     32'h3, 32'h0,       32'h80FF1234, 1, 2, 32'h2000,     0, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 0);
        run_op("lbu",  4'b0101, 32'h2000,     32'h3, 32'h0,       32'h80FF1234, 1, 2, 32'h2000,     0, 4'b0000, 32'h0,        32'h00000080, 0, 0);
        run_op("lb0",  4'b0001, 32'h2000,     32'h0, 32'h0,       32'h80FF1234, 1, 2, 32'h2000,     0, 4'b0000, 32'h0,        32'h00000034, 0, 0);
        run_op("lh",   4'b0010, 32'h2000,     32'h2, 32'h0,       32'h80FF1234, 1, 2, 32'h2000,     0, 4'b0000, 32'h0,        32'hFFFF80FF, 0, 0);
        run_op("lhu",  4'b0110, 32'h2000,     32'h2, 32'h0,       32'h80FF1234, 1, 2, 32'h2000,     0, 4'b0000, 32'h0,        32'h000080FF, 0, 0);
        run_op("lh0",  4'b0010, 32'h2000,     32'h0, 32'h0,       32'h12348765, 1, 2, 32'h2000,     0, 4'b0000, 32'h0,        32'hFFFF8765, 0, 0);
        run_op("sb",   4'b1001, 32'h3000,     32'h1, 32'h000000A5, 32'h0,       1, 2, 32'h3000,     1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0);
        run_op("sh",   4'b1010, 32'h3000,     32'h2, 32'h00001234, 32'h0,       1, 2, 32'h3000,     1, 4'b1100, 32'h12341234, 32'h0,        0, 0);
        run_op("sw",   4'b1100, 32'h3000,     32'h8, 32'hCAFEF00D, 32'h0,       1, 2, 32'h3008,     1, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0);
        run_op("mlw",  4'b0011, 32'h4000,     32'h2, 32'h0,       32'h0,        1, 1, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 0);
        run_op("msh",  4'b1010, 32'h4000,     32'h1, 32'hFFFF,    32'h0,        1, 1, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 0);
        run_op("wrap", 4'b0011, 32'hFFFFFFFC, 32'h8, 32'h0,       32'h11223344, 1, 2, 32'h00000004, 0, 4'b0000, 32'h0,        32'h11223344, 0, 0);
        run_op("nop",  4'b0000, 32'h5000,     32'h0, 32'h0,       32'h0,        1, 1, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 0);
        run_op("nop7", 4'b0111, 32'h5000,     32'h1, 32'h0,       32'h0,        1, 1, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        0, 0);

        // Wait states: ack in REQ cycle 3, and in cycle 4 (same cycle as timeout)
        run_op("ws3",  4'b0011, 32'h6000,     32'h0, 32'h0,       32'hA1B2C3D4, 3, 4, 32'h6000,     0, 4'b0000, 32'h0,        32'hA1B2C3D4, 0, 0);
        run_op("ws4",  4'b1100, 32'h6000,     32'h4, 32'h55AA55AA, 32'h0,       4, 5, 32'h6004,     1, 4'b1111, 32'h55AA55AA, 32'h0,        0, 0);

        // Reset during REQ
        @(negedge clock_in);
        valid_in  = 1'b1;
        uop_in    = 4'b0011;
        a_data_in = 32'h7000;
        b_data_in = 32'h0;
        @(negedge clock_in);
        valid_in = 1'b0;
        chk("rreq_c1", 32'(mem_req_out), 32'd1);
        @(negedge clock_in);
        chk("rreq_c2", 32'(mem_req_out), 32'd1);
        reset_in = 1'b0;
        #1;
        chk("rreq_drop",  32'(mem_req_out),   32'd0);
        chk("rreq_ready", 32'(ready_out),     32'd1);
        chk("rreq_state", 32'(dbg_state_out), 32'd0);
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'hFFFFFFFF;
        @(negedge clock_in);
        reset_in = 1'b1;
        @(negedge clock_in);
        chk("rreq_lateack_done", 32'(done_out),      32'd0);
        chk("rreq_lateack_req",  32'(mem_req_out),   32'd0);
        chk("rreq_post_ready",   32'(ready_out),     32'd1);
        chk("rreq_post_state",   32'(dbg_state_out), 32'd0);
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'd0;

        // Timeout: no ack -> 4 REQ cycles then bus error
        run_op("tmo",  4'b0101, 32'h8000,     32'h1, 32'h0,       32'h0,        0, 5, 32'h8000,     0, 4'b0000, 32'h0,        32'h0,        0, 1);
        run_op("tmos", 4'b1001, 32'h8000,     32'h3, 32'h0000003C, 32'h0,       0, 5, 32'h8000,     1, 4'b1000, 32'h3C3C3C3C, 32'h0,        0, 1);
        // Next op after a timeout completes normally
        run_op("after",4'b0010, 32'h9000,     32'h0, 32'h0,       32'h00007FFF, 2, 3, 32'h9000,     0, 4'b0000, 32'h0,        32'h00007FFF, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Sequencer for the load/store unit.
- Accepts one decoded load/store uOP at a time from issue and computes the effective address as base + immediate.
- Checks alignment, drives a single-outstanding request/ack data-memory port with byte strobes, then returns sign/zero-extended load data or store completion to writeback.
- Sits between issue/register read and the data memory interface; exceptions are reported as one-cycle flags.

Parameters:
- TIMEOUT, 255: max cycles a memory request may wait for mem_ack_in before abort; 0 disables the timeout.

Ports:
- clock_in  input  1  system clock; all state on rising edge
- reset_in  input  1  asynchronous, active-low reset
- valid_in  input  1  issue presents a uOP
- ready_out  output  1  controller can accept a uOP (IDLE)
- uop_in  input  4  LSU micro-op: 0001 LB, 0010 LH, 0011 LW, 0101 LBU, 0110 LHU, 1001 SB, 1010 SH, 1100 SW; all other codes are NOP
- a_data_in  input  32  base register value
- b_data_in  input  32  immediate offset
- st_data_in  input  32  store source register value
- mem_req_out  output  1  memory request valid
- mem_we_out  output  1  1 = store
- mem_addr_out  output  32  word-aligned address, ea[31:2] followed by 2'b00
- mem_wstrb_out  output  4  byte enables
- mem_wdata_out  output  32  store data replicated into lanes
- mem_ack_in  input  1  memory completes request this cycle
- mem_rdata_in  input  32  read word, valid with mem_ack_in
- done_out  output  1  one-cycle completion pulse
- res_data_out  output  32  load result (0 for stores, NOP, exceptions)
- misalign_out  output  1  with done_out: access misaligned, no memory op issued
- bus_err_out  output  1  with done_out: request timed out

Behaviour:
- Reset (reset_in low, async): state IDLE, ready_out=1, and all other outputs 0. Timeout counter and latched uOP/address/data are cleared.
- Reset mid-request: mem_req_out drops immediately. A late mem_ack_in after reset is ignored.
- Effective address: ea = a_data_in + b_data_in, mod 2^32; carry is discarded.
- States: IDLE, REQ, RESP.
- IDLE: ready_out=1. When valid_in=1, latch uop, ea and st_data, then branch:
  - NOP code: go to RESP.
  - Misaligned access (halfword with ea[0]=1, or word with ea[1:0]!=0): set the misalign flag, go to RESP. No mem_req_out is issued.
  - Otherwise: go to REQ.
- REQ: ready_out=0.
  - mem_req_out, mem_we_out, mem_addr_out, mem_wstrb_out and mem_wdata_out are held stable every cycle until the ack.
  - On mem_ack_in=1: capture rdata (loads), go to RESP.
  - The counter increments each REQ cycle without ack. When it reaches TIMEOUT with TIMEOUT!=0, set the bus_err flag and go to RESP.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins: normal completion.
- RESP: exactly one cycle. done_out=1 with res_data_out, misalign_out and bus_err_out valid. Return to IDLE; the counter clears.
- ready_out is 0 in REQ and RESP, so back-to-back uOPs are spaced at least one idle-accept cycle apart.
- mem_ack_in outside REQ is ignored.
- Latency: an accepted, aligned access with ack on the first REQ cycle gives done_out 2 cycles after acceptance. Misaligned or NOP gives done_out 1 cycle after acceptance.
- Strobes (sh = ea[1:0]):
  - SB: 4'b0001 << sh.
  - SH: 4'b0011 << sh (sh is 0 or 2).
  - SW: 4'b1111.
  - Loads: 4'b0000 with mem_we_out=0; the full word is read.
- Store data: SB replicates st_data[7:0] into all 4 lanes. SH replicates st_data[15:0] into both halves. SW passes st_data unchanged.
- Load extraction:
  - byte = rdata[8*sh+7 : 8*sh].
  - half = rdata[16*sh[1]+15 : 16*sh[1]].
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend; LW passes the word.
- Outputs other than done/res/flags are 0 outside REQ.

Test Plan:
- LW aligned: a=0x1000, b=0x4, ack on 1st REQ cycle, rdata=0xDEADBEEF -> mem_addr=0x1004, wstrb=0000, we=0; done 2 cycles after accept; res=0xDEADBEEF.
- LB/LBU: ea=0x2003, rdata=0x80FF1234 -> LB res=0xFFFFFF80, LBU res=0x00000080.
- SB and SH: SB ea=0x3001, st=0x000000A5 -> wstrb=0010, wdata=0xA5A5A5A5, we=1, res=0. SH ea=0x3002, st=0x1234 -> wstrb=1100, wdata=0x12341234.
- Misaligned: LW ea=0x4002, and SH ea=0x4001 -> mem_req never asserted; done and misalign_out together 1 cycle after accept; res=0.
- Wait states and timeout: TIMEOUT=4. Ack after 3 wait cycles -> normal completion, outputs stable throughout. No ack -> bus_err_out with done after 4 REQ cycles, and an ack in the 4th cycle gives normal completion. Assert reset_in low during REQ -> mem_req_out=0 immediately; after release, state is IDLE with ready_out=1.
- Wrap and NOP: a=0xFFFFFFFC, b=0x8, LW -> mem_addr=0x00000004. uop=0000 -> no request, done after 1 cycle, res=0, flags 0.
